mem_port_arbiter: RTL

- Sits between the pipelined CPU's IF stage and MEM stage and one single-ported, fixed-latency unified memory.
- Replaces the separate instruction and data memories. Grants one outstanding access at a time.
- Data accesses have priority; a starvation counter bounds instruction-fetch delay.
- Drives stall outputs that the hazard logic uses to freeze PC and the pipeline registers.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_arb_lat_cnt.sv | 30 +++
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} arb_owner_t;

  localparam int unsigned WORD_BYTES    = 8;
  localparam int unsigned INSTR_BYTES   = 4;
  localparam int unsigned WORD_OFF_W    = $clog2(WORD_BYTES);
  localparam int unsigned INSTR_SEL_BIT = $clog2(INSTR_BYTES);
  localparam int unsigned LAT_CNT_W     = 4;
  localparam int unsigned STARVE_W      = 4;

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// Loadable down-counter that flags the final cycle of a memory latency window.
module mem_arb_lat_cnt
  import mem_arb_pkg::*;
#(
  parameter int unsigned CNT_W = LAT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             last_c
);

  logic [CNT_W-1:0] cnt;

  // Load has priority; otherwise count down to zero and hold there.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign last_c = (cnt == CNT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency unified memory between instruction fetch and data access.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  arb_state_t          state;
  arb_owner_t          owner;
  logic [STARVE_W-1:0] starve_cnt;
  logic                half_hi;
  logic                is_store;

  logic grant_d_c;
  logic grant_i_c;
  logic d_misaligned_c;
  logic lat_load_c;
  logic lat_en_c;
  logic lat_last_c;
  logic unused_if_lo;

  // Fetch addresses are instruction aligned; the low byte-offset bits carry no information.
  assign unused_if_lo = ^if_addr[INSTR_SEL_BIT-1:0];

  // Data wins unless a waiting fetch has already been passed over STARVE_MAX times.
  assign d_misaligned_c = (d_addr[WORD_OFF_W-1:0] != '0);
  assign grant_d_c      = d_req && (!if_req || (starve_cnt < STARVE_W'(STARVE_MAX)));
  assign grant_i_c      = if_req && !grant_d_c;

  assign lat_load_c = (state == ISSUE);
  assign lat_en_c   = (state == WAIT);

  // Hazard logic freezes a requester until its completion pulse.
  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = d_req & ~d_ack;

  mem_arb_lat_cnt #(
    .CNT_W (LAT_CNT_W)
  ) u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (lat_load_c),
    .en       (lat_en_c),
    .load_val (LAT_CNT_W'(MEM_LAT)),
    .last_c   (lat_last_c)
  );

  // Arbitration FSM: grant, one-cycle memory strobe, latency wait, one-cycle ack.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= OWN_I;
      starve_cnt <= '0;
      half_hi    <= 1'b0;
      is_store   <= 1'b0;
      if_rdata   <= '0;
      if_ack     <= 1'b0;
      d_rdata    <= '0;
      d_ack      <= 1'b0;
      d_err      <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      if_ack  <= 1'b0;
      d_ack   <= 1'b0;
      d_err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_d_c) begin
            owner <= OWN_D;
            if (!if_req) begin
              starve_cnt <= '0;
            end else if (starve_cnt != STARVE_W'(STARVE_MAX)) begin
              starve_cnt <= starve_cnt + STARVE_W'(1);
            end
            if (d_misaligned_c) begin
              d_ack <= 1'b1;
              d_err <= 1'b1;
              state <= DONE;
            end else begin
              is_store  <= d_we;
              mem_req   <= 1'b1;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              state     <= ISSUE;
            end
          end else if (grant_i_c) begin
            owner      <= OWN_I;
            starve_cnt <= '0;
            is_store   <= 1'b0;
            half_hi    <= if_addr[INSTR_SEL_BIT];
            mem_req    <= 1'b1;
            mem_addr   <= {if_addr[ADDR_W-1:WORD_OFF_W], WORD_OFF_W'(0)};
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (lat_last_c) begin
            state <= DONE;
            if (owner == OWN_I) begin
              if_rdata <= half_hi ? mem_rdata[63:32] : mem_rdata[31:0];
              if_ack   <= 1'b1;
            end else begin
              if (!is_store) begin
                d_rdata <= mem_rdata;
              end
              d_ack <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
